// File: rtl/sipo_deserializer_pkg.sv
// rtl/sipo_deserializer_pkg.sv - shared constants and helpers for the SIPO receiver
//
// Purpose: constants shared by the receiver, its shift core and the paired PISO.
//   WIDTH_DEF : default word width in bits
//   MSB_FIRST : wire bit order; the first bit on the link is the word MSB
//   cnt_width : width of a bit counter that must hold 0..w-1 (never below 1)
package sipo_deserializer_pkg;

   localparam int WIDTH_DEF = 4;
   localparam bit MSB_FIRST = 1'b1;

   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - serial shift register, bit counter and word-complete strobe
//
// Purpose: accumulates MSB-first serial bits and flags the edge at which a word completes.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   clr               synchronous framing restart (drops the partial word)
//   sin_valid, sin    serial bit strobe and data
//   word [WIDTH-1:0]  word that completes if the current bit is accepted (combinational)
//   complete          current bit is accepted and is the last bit of a word
//   busy              a partial word is in progress (counter non-zero)
module sipo_shift_core
   import sipo_deserializer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             sin_valid,
   input  logic             sin,
   output logic [WIDTH-1:0] word,
   output logic             complete,
   output logic             busy
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // The oldest bit always falls out at completion, so only WIDTH-1 bits are
   // ever observable; the top bit of a WIDTH-wide register would be dead.
   logic [WIDTH-2:0] sr;
   logic [CW-1:0]    cnt;
   logic             accept;

   assign accept   = sin_valid & ~clr;
   assign complete = accept & (cnt == LAST);
   assign word     = {sr, sin};
   assign busy     = (cnt != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (clr) begin
         sr  <= '0;
         cnt <= '0;
      end else if (sin_valid) begin
         sr  <= word[WIDTH-2:0];
         cnt <= complete ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in parallel-out receiver with one-word holding buffer
//
// Purpose: reassembles an MSB-first serial stream into WIDTH-bit words and offers
// each on a ready/valid port through a single holding register.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   clr                  synchronous framing restart; held word and handshake unaffected
//   sin_valid, sin       serial bit strobe and data (first bit -> pout[WIDTH-1])
//   pout [WIDTH-1:0]     held word (retains its value after being popped)
//   pout_valid           held word not yet consumed
//   pout_ready           consumer takes pout this cycle
//   overrun              one-cycle pulse: a completed word was dropped, buffer full
//   busy                 partial word in progress
module sipo_deserializer
   import sipo_deserializer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             sin_valid,
   input  logic             sin,
   output logic [WIDTH-1:0] pout,
   output logic             pout_valid,
   input  logic             pout_ready,
   output logic             overrun,
   output logic             busy
);

   logic [WIDTH-1:0] word;
   logic             complete;
   logic [WIDTH-1:0] hold;
   logic             full;
   logic             hold_free;

   sipo_shift_core #(.WIDTH(WIDTH)) u_core (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .sin_valid (sin_valid),
      .sin       (sin),
      .word      (word),
      .complete  (complete),
      .busy      (busy)
   );

   // A pop on the same edge frees the slot, so a completing word can replace
   // the departing one with no bubble in pout_valid.
   assign hold_free = ~full | pout_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold    <= '0;
         full    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= complete & ~hold_free;
         if (complete && hold_free) begin
            hold <= word;
            full <= 1'b1;
         end else if (full && pout_ready) begin
            full <= 1'b0;
         end
      end
   end

   assign pout       = hold;
   assign pout_valid = full;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - scoreboard bench for sipo_deserializer
module tb_sipo_deserializer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         clr = 1'b0;
   logic         sin_valid = 1'b0;
   logic         sin = 1'b0;
   logic [W-1:0] pout;
   logic         pout_valid;
   logic         pout_ready = 1'b0;
   logic         overrun;
   logic         busy;

   sipo_deserializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .sin_valid  (sin_valid),
      .sin        (sin),
      .pout       (pout),
      .pout_valid (pout_valid),
      .pout_ready (pout_ready),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // reference model state
   int bitq[$];
   int exp_q[$];
   int m_full = 0;
   int m_over = 0;

   // directed expectations handed to the monitor
   int d_en = 0;
   int d_exp = 0;
   int d_vexp = 0;
   int done = 0;

   // monitor state
   int rd_idx = 0;
   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: bits collect in a list; every W bits form a word by positional value.
   // One-slot buffer: a word is kept only if the slot is empty or being taken.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         bitq.delete();
         m_full = 0;
         m_over = 0;
      end else begin
         int took;
         int w;
         int popping;
         took    = 0;
         m_over  = 0;
         popping = (m_full != 0) && pout_ready;
         if (clr) begin
            bitq.delete();
         end else if (sin_valid) begin
            bitq.push_back(int'(sin));
            if (bitq.size() == W) begin
               w = 0;
               foreach (bitq[i]) w = w * 2 + bitq[i];
               bitq.delete();
               if (m_full == 0 || pout_ready) begin
                  exp_q.push_back(w);
                  took = 1;
               end else begin
                  m_over = 1;
               end
            end
         end
         if (took != 0) m_full = 1;
         else if (popping) m_full = 0;
      end
   end

   // Monitor: samples 1 time unit after each falling clock edge or reset assertion.
   always @(negedge clk or negedge rst) begin
      #1;
      if (!rst) begin
         chk("rst_pout", int'(pout), 0);
         chk("rst_pout_valid", int'(pout_valid), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_overrun", int'(overrun), 0);
         rd_idx = exp_q.size();
      end else if (done != 0) begin
         chk("sb_drained", rd_idx, exp_q.size());
         $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
         $finish;
      end else begin
         chk("pout_valid", int'(pout_valid), m_full);
         chk("busy", int'(busy), int'(bitq.size() != 0));
         chk("overrun", int'(overrun), m_over);
         if (d_en != 0) begin
            chk("dir_pout", int'(pout), d_exp);
            chk("dir_pout_valid", int'(pout_valid), d_vexp);
         end
         if (pout_valid) begin
            if (rd_idx >= exp_q.size()) begin
               chk("pout_nodata", 1, 0);
            end else begin
               chk("pout", int'(pout), exp_q[rd_idx]);
               if (pout_ready) rd_idx++;
            end
         end
      end
   end

   task automatic cyc(input logic v, input logic s, input logic r, input logic c);
      sin_valid  = v;
      sin        = s;
      pout_ready = r;
      clr        = c;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_hold(input int val, input int vld, input logic r);
      d_exp  = val;
      d_vexp = vld;
      d_en   = 1;
      cyc(1'b0, 1'b0, r, 1'b0);
      d_en   = 0;
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic r_last);
      logic [W-1:0] t;
      t = w;
      for (int i = 0; i < W; i++) begin
         cyc(1'b1, t[W-1], (i == W - 1) ? r_last : 1'b0, 1'b0);
         t = t << 1;
      end
   endtask

   initial begin
      logic [W-1:0] piso;
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      // basic word, held until popped; pout keeps its value afterwards
      send_word(4'b1011, 1'b0);
      expect_hold(4'hB, 1, 1'b0);
      expect_hold(4'hB, 1, 1'b1);
      expect_hold(4'hB, 0, 1'b0);

      // gapped bits, then back-to-back completion while popping
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      expect_hold(4'h6, 1, 1'b0);
      send_word(4'b1100, 1'b1);
      expect_hold(4'hC, 1, 1'b1);

      // overrun: 5 dropped while A is held
      send_word(4'hA, 1'b0);
      send_word(4'h5, 1'b0);
      expect_hold(4'hA, 1, 1'b0);
      expect_hold(4'hA, 1, 1'b1);

      // clr discards the partial word and its own bit
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      send_word(4'b0001, 1'b0);
      expect_hold(4'h1, 1, 1'b1);

      // loopback from a PISO loaded with 9
      piso = 4'h9;
      for (int i = 0; i < W; i++) begin
         cyc(1'b1, piso[W-1], 1'b0, 1'b0);
         piso = piso << 1;
      end
      expect_hold(4'h9, 1, 1'b1);

      // reset mid-word with the holding register full
      send_word(4'h6, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         cyc(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0));
      end

      repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      done = 1;
      repeat (2) @(posedge clk);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out receiver paired with the 4-bit PISO shift register: it reassembles an MSB-first serial bit stream into WIDTH-bit words. Each completed word is presented on a ready/valid output with a one-word holding buffer, so shifting continues while the consumer is busy. Placed at the receive end of the serial link, feeding parallel logic.

## Interface
- WIDTH, 4, word width in bits (≥2); first received bit lands in pout[WIDTH-1]
- clk  in  1  rising-edge clock; all state in this single domain
- rst  in  1  asynchronous, active-low reset; sets all state to reset values
- clr  in  1  synchronous framing restart: discards partial word, count to 0
- sin_valid  in  1  sin carries a valid bit this cycle
- sin  in  1  serial data bit, MSB first
- pout  out  WIDTH  assembled word from holding register
- pout_valid  out  1  holding register holds an unconsumed word
- pout_ready  in  1  consumer accepts pout this cycle
- overrun  out  1  one-cycle pulse: completed word dropped because holding register full
- busy  out  1  partial word in progress (bit count ≠ 0)

## Operation
- Internal state: shift register sr[WIDTH-1:0], bit counter cnt (0..WIDTH-1, width $clog2(WIDTH)), holding register hold[WIDTH-1:0], flag full.
- Reset (rst=0): sr=0, cnt=0, hold=0, full=0, overrun=0; thus pout=0, pout_valid=0, busy=0.
- Bit accept: edge with sin_valid=1 and clr=0: sr <= {sr[WIDTH-2:0], sin}; cnt increments.
- Word complete: accepted bit with cnt==WIDTH-1: cnt wraps to 0; word {sr[WIDTH-2:0], sin} transfers to hold if hold is free at that edge.
- Hold free at an edge when full=0 or (full=1 and pout_ready=1).
- Pop: full=1 and pout_ready=1 with no word completion → full <= 0; hold keeps its value (pout not cleared).
- Simultaneous pop and completion: hold loads new word, full stays 1 (back-to-back, no bubble).
- Completion while full=1 and pout_ready=0: new word discarded, hold unchanged, overrun=1 for exactly the following cycle; cnt still wraps to 0.
- clr=1: sr <= 0, cnt <= 0 regardless of sin_valid (bit that cycle discarded); hold/full unaffected; pop still honored.
- sin_valid=0: sr and cnt hold; gaps between bits of any length allowed.
- pout_ready while full=0: ignored.
- pout_valid = full; busy = (cnt != 0); overrun registered.

## Timing
- Latency: WIDTH-th bit accepted at edge N → pout_valid=1 and pout valid from edge N until the popping edge.
- Peak throughput: one bit per cycle; a word every WIDTH cycles sustained with pout_ready=1.
- pout/pout_valid stable while pout_valid=1 and pout_ready=0, except none (no overwrite on overrun).
- Asynchronous reset asserts immediately; deassertion synchronized externally; reset mid-word discards the partial word and any held word.
- No combinational path from inputs to outputs.

## Structure
- Shared package: WIDTH default constant, counter width function, MSB-first bit-order constant shared with the PISO.
- One natural sub-module: sipo_shift_core (sr + cnt + complete strobe); top adds holding register, handshake and overrun.

## Test plan
- Reset: drive rst=0 mid-stream with full=1 → pout=0, pout_valid=0, busy=0, overrun=0 immediately.
- Basic word: WIDTH=4, sin 1,0,1,1 on consecutive cycles, pout_ready=0 → pout=4'b1011, pout_valid=1 after 4th edge; hold until pout_ready=1 one cycle, then pout_valid=0.
- Gapped bits + back-to-back: bits 0,1,1,0 with sin_valid gaps, then 1,1,0,0 with pout_ready=1 at completion → 4'b0110 then 4'b1100, pout_valid continuously 1, no overrun.
- Overrun: hold 4'hA unconsumed, complete 4'h5 with pout_ready=0 → overrun pulses 1 cycle, pout stays 4'hA.
- clr: shift 1,1 then clr=1 with sin_valid=1, then 0,0,0,1 → pout=4'b0001, busy=0 after clr.
- Loopback: PISO loads 4'h9 and shifts into this block with sin_valid=1 for 4 cycles → pout=4'h9.
